// File: rtl/pulse_bram_arbiter.sv
// Round-robin owner of the shared pulse-accumulation BRAM port (0 = neutron, 1 = gamma).
// Whole read-modify-write bursts are granted; the owner's beats reach the BRAM one cycle later.
module pulse_bram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        done,
  output logic [1:0]        grant,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_din,
  input  logic [DATA_W-1:0] m1_din,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic              m0_ena,
  input  logic              m1_ena,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data_in,
  output logic              bram_we,
  output logic              bram_ena,
  input  logic [DATA_W-1:0] bram_data_out,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_data_in_q;
  logic              bram_we_q;
  logic              bram_ena_q;
  logic              busy_q;
  logic              timeout_err_q;
  logic              rr_ptr_q;
  logic [15:0]       hold_cnt_q;
  logic [15:0]       hold_cnt_d;

  logic              arb_win;
  logic              own_id;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_din;
  logic              own_we;
  logic              own_ena;
  logic              own_done;
  logic              own_req;
  logic              hold_hit;
  logic              release_now;
  logic              beat_fwd;

  // Single requester wins outright; on contention rr_ptr names the one not served last.
  always_comb begin
    arb_win = 1'b0;
    case (req)
      2'b01:   arb_win = 1'b0;
      2'b10:   arb_win = 1'b1;
      2'b11:   arb_win = rr_ptr_q;
      default: arb_win = 1'b0;
    endcase
  end

  assign own_id   = (state_q == S_OWN1);
  assign own_addr = own_id ? m1_addr : m0_addr;
  assign own_din  = own_id ? m1_din  : m0_din;
  assign own_we   = own_id ? m1_we   : m0_we;
  assign own_ena  = own_id ? m1_ena  : m0_ena;
  assign own_done = done[own_id];
  assign own_req  = req[own_id];

  // hold_cnt_q is the 1-based index of the current owned cycle.
  assign hold_cnt_d  = hold_cnt_q + 16'd1;
  assign hold_hit    = (hold_cnt_q == 16'(MAX_HOLD));
  assign release_now = own_done | ~own_req | hold_hit;
  // A done beat always lands; a dropped request or an expired hold discards the beat.
  assign beat_fwd    = own_done | (own_req & ~hold_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      grant_q        <= 2'b00;
      bram_addr_q    <= '0;
      bram_data_in_q <= '0;
      bram_we_q      <= 1'b0;
      bram_ena_q     <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      rr_ptr_q       <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      bram_we_q     <= 1'b0;
      bram_ena_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_OWN0, S_OWN1: begin
          bram_addr_q    <= own_addr;
          bram_data_in_q <= own_din;
          bram_ena_q     <= beat_fwd & own_ena;
          bram_we_q      <= beat_fwd & own_ena & own_we;
          if (release_now) begin
            state_q       <= S_GAP;
            grant_q       <= 2'b00;
            busy_q        <= 1'b0;
            hold_cnt_q    <= '0;
            timeout_err_q <= ~own_done & own_req & hold_hit;
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        default: begin
          // IDLE and GAP both arbitrate; GAP guarantees one grant-free cycle between owners.
          if (|req) begin
            state_q    <= arb_win ? S_OWN1 : S_OWN0;
            grant_q    <= arb_win ? 2'b10 : 2'b01;
            busy_q     <= 1'b1;
            rr_ptr_q   <= ~arb_win;
            hold_cnt_q <= 16'd1;
          end else begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign bram_addr    = bram_addr_q;
  assign bram_data_in = bram_data_in_q;
  assign bram_we      = bram_we_q;
  assign bram_ena     = bram_ena_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign rd_data      = bram_data_out;

endmodule

// File: tb/tb_pulse_bram_arbiter.sv
// Bench for pulse_bram_arbiter: scoreboard of forwarded beats and read data against a BRAM model,
// plus a second instance with a short hold limit for the revoke scenario.
module tb_pulse_bram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, done;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_we, m1_we, m0_ena, m1_ena;
  logic [DW-1:0] bram_data_out;
  logic [1:0]    grant;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data_in;
  logic          bram_we, bram_ena, busy, timeout_err;

  logic [1:0]    h_grant;
  logic [DW-1:0] h_rd_data;
  logic [AW-1:0] h_bram_addr;
  logic [DW-1:0] h_bram_data_in;
  logic          h_bram_we, h_bram_ena, h_busy, h_timeout_err;
  logic [DW-1:0] h_bram_data_out;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit mon_on  = 1'b1;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];

  pulse_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_din(m0_din), .m1_din(m1_din),
    .m0_we(m0_we), .m1_we(m1_we), .m0_ena(m0_ena), .m1_ena(m1_ena),
    .rd_data(rd_data), .bram_addr(bram_addr), .bram_data_in(bram_data_in),
    .bram_we(bram_we), .bram_ena(bram_ena), .bram_data_out(bram_data_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  pulse_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) u_hold (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(h_grant),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_din(m0_din), .m1_din(m1_din),
    .m0_we(m0_we), .m1_we(m1_we), .m0_ena(m0_ena), .m1_ena(m1_ena),
    .rd_data(h_rd_data), .bram_addr(h_bram_addr), .bram_data_in(h_bram_data_in),
    .bram_we(h_bram_we), .bram_ena(h_bram_ena), .bram_data_out(h_bram_data_out),
    .busy(h_busy), .timeout_err(h_timeout_err)
  );

  assign h_bram_data_out = '0;

  always #5 clk = ~clk;

  // BRAM model: read-first, one-cycle read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    bram_data_out = '0;
  end
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_we) mem[bram_addr[9:2]] <= bram_data_in;
      bram_data_out <= mem[bram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; done = 2'b00;
    m0_we = 1'b0; m0_ena = 1'b0; m1_we = 1'b0; m1_ena = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    beat_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Owner presents n beats from base; the non-owner hammers writes that must never land.
  task automatic owner_beats(input int who, input int n, input logic wr,
                             input logic [31:0] base, input bit skip);
    logic [31:0] a, d;
    logic        e;
    beat_t       b;
    $display("burst owner=%0d beats=%0d wr=%0b base=%h", who, n, wr, base);
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      d = $urandom;
      e = !(skip && (i % 3 == 2));
      if (who == 0) begin
        m0_addr = a; m0_din = d; m0_we = wr; m0_ena = e;
        m1_addr = $urandom; m1_din = $urandom; m1_we = 1'b1; m1_ena = 1'b1;
      end else begin
        m1_addr = a; m1_din = d; m1_we = wr; m1_ena = e;
        m0_addr = $urandom; m0_din = $urandom; m0_we = 1'b1; m0_ena = 1'b1;
      end
      if (e) begin
        b.addr = a; b.we = wr; b.din = d;
        beat_q.push_back(b);
        if (wr) shadow[a[9:2]] = d;
        else    rd_q.push_back(shadow[a[9:2]]);
      end
      if (i == n - 1) done[who] = 1'b1;
      tick();
    end
    done = 2'b00;
    m0_we = 1'b0; m0_ena = 1'b0; m1_we = 1'b0; m1_ena = 1'b0;
  endtask

  // Scoreboard consumer: every forwarded beat must be the next expected one.
  initial begin : monitor
    beat_t b;
    bit    rd_pend;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_on) begin
        rd_pend = 1'b0;
      end else begin
        if (rd_pend) begin
          if (rd_q.size() == 0) chk("rd_q_underflow", 32'(rd_q.size()), 32'd1);
          else                  chk("rd_data", rd_data, rd_q.pop_front());
        end
        rd_pend = 1'b0;
        if (!bram_ena) begin
          chk("we_without_ena", {31'd0, bram_we}, 32'd0);
        end else if (beat_q.size() == 0) begin
          chk("spurious_beat", {31'd0, bram_ena}, 32'd0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", bram_addr, b.addr);
          chk("beat_we", {31'd0, bram_we}, {31'd0, b.we});
          chk("beat_din", bram_data_in, b.din);
          if (!b.we) rd_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [1:0] exp_g;
    for (int i = 0; i < 256; i++) shadow[i] = {16'hC0DE, 16'(i)};

    // Reset with garbage on every input.
    rst_n = 1'b0;
    req = 2'($urandom); done = 2'($urandom);
    m0_addr = $urandom; m1_addr = $urandom; m0_din = $urandom; m1_din = $urandom;
    m0_we = 1'b1; m1_we = 1'b1; m0_ena = 1'b1; m1_ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bram_addr", bram_addr, 32'd0);
    chk("rst_bram_din", bram_data_in, 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_bram_ena", 32'(bram_ena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_ena", 32'(bram_ena), 32'd0);
    end

    // Contention: owner order must alternate 0,1,0,1 with one grant-free cycle between.
    req = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_busy", 32'(busy), 32'd1);
      owner_beats(k % 2, 3, 1'b0, 32'h40 + 32'(k * 16), 1'b0);
      chk("gap_grant", 32'(grant), 32'd0);
      chk("gap_busy", 32'(busy), 32'd0);
      if (k == 3) req = 2'b00;
      tick();
    end

    // Single 13-beat read burst by requester 0.
    req = 2'b01;
    tick();
    chk("single_grant", 32'(grant), 32'd1);
    owner_beats(0, 13, 1'b0, 32'h0, 1'b0);
    chk("single_release", 32'(grant), 32'd0);
    req = 2'b00;
    repeat (3) tick();

    // Write burst with holes (we=1, ena=0), then read back what landed.
    req = 2'b01;
    tick();
    chk("wr_grant", 32'(grant), 32'd1);
    owner_beats(0, 7, 1'b1, 32'h100, 1'b1);
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    chk("rb_grant", 32'(grant), 32'd1);
    owner_beats(0, 7, 1'b0, 32'h100, 1'b0);
    req = 2'b00;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(beat_q.size() + rd_q.size()), 32'd0);

    // Hold limit on the MAX_HOLD=8 instance, requester 1 pending throughout.
    mon_on = 1'b0;
    do_reset();
    req = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_g = (k <= 8) ? 2'b01 : ((k == 9) ? 2'b00 : 2'b10);
      chk("hold_grant", 32'(h_grant), 32'(exp_g));
      chk("hold_ena", 32'(h_bram_ena), (k >= 2 && k <= 8) ? 32'd1 : 32'd0);
      chk("hold_timeout", 32'(h_timeout_err), (k == 9) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 8) chk("hold_addr", h_bram_addr, 32'(4 * (k - 1)));
      m0_addr = 32'(4 * k); m0_din = $urandom; m0_we = 1'b0; m0_ena = 1'b1;
    end
    $display("hold-limit burst done");
    idle_inputs();

    // Reset in the middle of the 5th write beat.
    do_reset();
    mon_on = 1'b1;
    req = 2'b01;
    tick();
    chk("mr_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      m0_addr = 32'h200 + 32'(4 * i); m0_din = $urandom; m0_we = 1'b1; m0_ena = 1'b1;
      if (i < 3) begin
        b.addr = m0_addr; b.we = 1'b1; b.din = m0_din;
        beat_q.push_back(b);
      end
      if (i < 4) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_we", 32'(bram_we), 32'd0);
    chk("mr_async_ena", 32'(bram_ena), 32'd0);
    chk("mr_async_grant", 32'(grant), 32'd0);
    chk("mr_async_busy", 32'(busy), 32'd0);
    chk("mr_async_addr", bram_addr, 32'd0);
    chk("mr_beats_seen", 32'(beat_q.size()), 32'd0);
    $display("mid-burst reset applied");
    do_reset();
    req = 2'b11;
    tick();
    chk("mr_rr_restart", 32'(grant), 32'd1);
    done = 2'b01;
    req = 2'b00;
    tick();
    done = 2'b00;
    chk("mr_release", 32'(grant), 32'd0);
    repeat (3) tick();
    chk("final_drained", 32'(beat_q.size() + rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_bram_arbiter.md
# pulse_bram_arbiter

Two-port round-robin arbiter that shares the single pulse-accumulation BRAM port between two pulse generators: requester 0 is the neutron generator and requester 1 is the gamma generator. Each generator performs a read-modify-write burst over its pulse window. The arbiter grants whole bursts, forwards the owner's BRAM signals through one register stage, inserts a one-cycle idle gap between owners, and revokes a grant that exceeds a hold limit. It sits between the generators and the BRAM model in the pulse-generation top level.

## Interface
- ADDR_W, 32, BRAM byte-address width
- DATA_W, 32, BRAM data width (fp32 words)
- MAX_HOLD, 64, maximum number of owned cycles per grant before forced revoke; legal range 2..65535
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-requester level request; bit 0 = neutron, bit 1 = gamma
- done  in  2  per-requester release pulse; sampled only for the current owner
- grant  out  2  one-hot ownership; never more than one bit set
- m0_addr, m1_addr  in  ADDR_W  requester BRAM address
- m0_din, m1_din  in  DATA_W  requester write data
- m0_we, m1_we  in  1  requester write enable
- m0_ena, m1_ena  in  1  requester BRAM enable
- rd_data  out  DATA_W  bram_data_out passed through combinationally to both requesters
- bram_addr  out  ADDR_W  registered BRAM address
- bram_data_in  out  DATA_W  registered BRAM write data
- bram_we  out  1  registered write enable
- bram_ena  out  1  registered BRAM enable
- bram_data_out  in  DATA_W  BRAM read data with 1-cycle read latency
- busy  out  1  high in OWN0/OWN1
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- States: IDLE, OWN0, OWN1, GAP.
- Reset values: IDLE, grant=0, bram_addr=0, bram_data_in=0, bram_we=0, bram_ena=0, busy=0, timeout_err=0, rr_ptr=0 (requester 0 has priority first), hold_cnt=0.
- **Arbitration** (in IDLE or GAP):
  - If exactly one req bit is set, that requester wins.
  - If both are set, the requester not served last wins (rr_ptr).
  - With no request, the next state is IDLE.
  - On every grant, rr_ptr is set so that the other requester has priority next time.
- **OWNx forwarding:**
  - Each cycle: bram_addr <= mx_addr, bram_data_in <= mx_din, bram_ena <= mx_ena, bram_we <= mx_we & mx_ena.
  - The non-owner's inputs are ignored.
- **Outside OWNx:** bram_ena <= 0 and bram_we <= 0; bram_addr and bram_data_in hold their values.
- **Release:**
  - In OWNx, done[x]=1 or req[x]=0 causes the next state to be GAP.
  - A done-cycle beat is still forwarded when done[x]=1.
  - A beat is dropped when only req[x] falls.
- **Hold limit:**
  - hold_cnt counts 1..MAX_HOLD over the OWN cycles.
  - If hold_cnt reaches MAX_HOLD with no release in that cycle, that cycle's beat is suppressed (ena=0, we=0) and the next state is GAP.
  - timeout_err=1 for the GAP cycle.
- **Simultaneous events:**
  - If done[x] coincides with the hold limit, it is a normal release with no timeout_err.
  - If the owner re-requests in the same cycle it releases, it loses to a pending other requester.
  - A done pulse from the non-owner is ignored.
- **Reset mid-burst:** all outputs return to their reset values immediately; any in-flight write is not guaranteed.

## Timing
- req[x] seen in IDLE at edge t → grant[x]=1 and busy=1 from t+1.
- A beat presented by the owner in cycle c appears on the bram_* outputs in cycle c+1.
- Read data for that beat is on rd_data in cycle c+2.
- Owner's done at cycle c → grant=0 from c+1 (GAP); bram_ena carries the done beat at c+1 and is 0 at c+2.
- The next owner's grant is at c+2 at the earliest, so there is at least one cycle with grant=0 between owners.
- The gap is required because generator address sequencing restarts on grant.
- Grant latency with no contention is 1 cycle; worst-case wait is MAX_HOLD+2 cycles.

## Test plan
- **Reset:** rst_n=0 with random inputs → every output at its reset value. rst_n released with req=2'b00 → grant stays 0 and bram_ena stays 0.
- **Single burst:** req=01, m0 presents 13 reads at addr 0..48 step 4, then done → grant=01 one cycle after req. bram_addr trails m0_addr by 1 cycle. rd_data equals the BRAM contents 2 cycles after each address. grant=00 the cycle after done.
- **Contention:** req=11 from IDLE with rr_ptr=0 → OWN0 first. After done[0], one GAP cycle, then grant=10. Repeat req=11 → order alternates 0,1,0,1.
- **Write isolation:** m1_we=1, m1_ena=1 while grant=01 → bram_we never reflects m1. Owner m0_we=1 with m0_ena=0 → bram_we=0.
- **Hold limit:** MAX_HOLD=8, owner never asserts done → grant drops after the 8th owned cycle. The 8th beat is not forwarded. timeout_err is high for exactly 1 cycle. The other pending requester is granted the following cycle.
- **Mid-burst reset:** rst_n=0 during the 5th write beat → bram_we=0, bram_ena=0 and grant=0 asynchronously. After release, arbitration restarts with requester 0 priority.
